// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter time-sharing one WIDTH-bit adder among NREQ requesters.
// Optional carry-out event counter enabled by defining ADDER_ARB_OVF_COUNT_EN.
module adder_share_arbiter #(
  parameter int WIDTH = 2,
  parameter int NREQ  = 2,
  parameter int IDW   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_bus,
  input  logic [NREQ*WIDTH-1:0] b_bus,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH:0]        sum,
  output logic [IDW-1:0]        done_id,
  output logic [7:0]            ovf_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [IDW-1:0]   ptr_reg, ptr_next;
  logic [IDW-1:0]   cur_id_reg, cur_id_next;
  logic [IDW-1:0]   done_id_reg, done_id_next;
  logic [WIDTH-1:0] op_a_reg, op_a_next;
  logic [WIDTH-1:0] op_b_reg, op_b_next;
  logic [NREQ-1:0]  gnt_reg, gnt_next;
  logic             done_reg, done_next;
  logic [WIDTH:0]   sum_reg, sum_next;
  logic [WIDTH:0]   add_result;

  logic [WIDTH-1:0] a_arr [NREQ];
  logic [WIDTH-1:0] b_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign a_arr[gi] = a_bus[gi*WIDTH +: WIDTH];
      assign b_arr[gi] = b_bus[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Search upward from ptr+1 with wrap; the last candidate checked is ptr itself.
  logic           pick_found;
  logic [IDW-1:0] pick_id;
  always_comb begin
    int             idx;
    logic [IDW-1:0] idx_w;
    pick_found = 1'b0;
    pick_id    = '0;
    idx        = 0;
    idx_w      = '0;
    for (int off = 1; off <= NREQ; off++) begin
      idx   = (int'(ptr_reg) + off) % NREQ;
      idx_w = IDW'(idx);
      if (!pick_found && req[idx_w]) begin
        pick_found = 1'b1;
        pick_id    = idx_w;
      end
    end
  end

  assign add_result = {1'b0, op_a_reg} + {1'b0, op_b_reg};

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    cur_id_next  = cur_id_reg;
    op_a_next    = op_a_reg;
    op_b_next    = op_b_reg;
    gnt_next     = '0;
    done_next    = 1'b0;
    sum_next     = sum_reg;
    done_id_next = done_id_reg;
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          op_a_next   = a_arr[pick_id];
          op_b_next   = b_arr[pick_id];
          cur_id_next = pick_id;
          ptr_next    = pick_id;
          gnt_next    = NREQ'(1) << pick_id;
          state_next  = EXEC;
        end
      end
      EXEC: begin
        sum_next     = add_result;
        done_id_next = cur_id_reg;
        done_next    = 1'b1;
        state_next   = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      ptr_reg     <= IDW'(NREQ - 1);
      cur_id_reg  <= '0;
      op_a_reg    <= '0;
      op_b_reg    <= '0;
      gnt_reg     <= '0;
      done_reg    <= 1'b0;
      sum_reg     <= '0;
      done_id_reg <= '0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      cur_id_reg  <= cur_id_next;
      op_a_reg    <= op_a_next;
      op_b_reg    <= op_b_next;
      gnt_reg     <= gnt_next;
      done_reg    <= done_next;
      sum_reg     <= sum_next;
      done_id_reg <= done_id_next;
    end
  end

`ifdef ADDER_ARB_OVF_COUNT_EN
  logic [7:0] ovf_cnt_reg;
  // Counts in step with the done pulse: the carry is taken from the sum being registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovf_cnt_reg <= 8'h00;
    else if (state_reg == EXEC && add_result[WIDTH] && ovf_cnt_reg != 8'hFF)
      ovf_cnt_reg <= ovf_cnt_reg + 8'd1;
  end
  assign ovf_cnt = ovf_cnt_reg;
`else
  assign ovf_cnt = 8'h00;
`endif

  assign gnt     = gnt_reg;
  assign done    = done_reg;
  assign sum     = sum_reg;
  assign done_id = done_id_reg;
  assign busy    = (state_reg == EXEC) || (state_reg == DONE);

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Scoreboard bench for adder_share_arbiter (WIDTH=2, NREQ=2); honours ADDER_ARB_OVF_COUNT_EN.
module tb_adder_share_arbiter;
  localparam int W = 2;
  localparam int N = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] a_bus, b_bus;
  logic [N-1:0]   gnt;
  logic           busy, done;
  logic [W:0]     sum;
  logic [0:0]     done_id;
  logic [7:0]     ovf_cnt;

  adder_share_arbiter #(.WIDTH(W), .NREQ(N), .IDW(1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_bus(a_bus), .b_bus(b_bus),
    .gnt(gnt), .busy(busy), .done(done), .sum(sum), .done_id(done_id), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int exp_gnt_q[$];
  int exp_id_q[$];
  int exp_sum_q[$];
  int exp_ovf = 0;
  bit spacing_en = 1'b0;
  int last_done = -1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Monitor: pops the expected response whenever the DUT presents gnt or done.
  always @(negedge clk) begin
    int e, s;
    if (rst_n) begin
      if (gnt != '0) begin
        if (exp_gnt_q.size() == 0) chk("gnt_unexpected", gnt, 0);
        else begin
          e = exp_gnt_q.pop_front();
          chk("gnt", gnt, 1 << e);
          chk("busy_in_exec", busy, 1);
        end
      end
      if (done) begin
        if (exp_sum_q.size() == 0) chk("done_unexpected", done, 0);
        else begin
          e = exp_id_q.pop_front();
          s = exp_sum_q.pop_front();
          chk("sum", sum, s);
          chk("done_id", done_id, e);
`ifdef ADDER_ARB_OVF_COUNT_EN
          if (s >= 4 && exp_ovf != 255) exp_ovf++;
`endif
          chk("ovf_cnt", ovf_cnt, exp_ovf);
          $display("done id=%0d sum=%0d ovf_cnt=%0d cycle=%0d", done_id, sum, ovf_cnt, cyc);
          if (spacing_en && last_done >= 0) chk("done_spacing", cyc - last_done, 3);
          last_done = cyc;
        end
      end
    end
  end

  task automatic wait_gnt(output int at);
    at = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gnt != '0) begin
        at = cyc;
        return;
      end
    end
    chk("gnt_timeout", 0, 1);
  endtask

  task automatic op(input logic [N-1:0] mask, input int id,
                    input logic [N*W-1:0] a, input logic [N*W-1:0] b, input int exp_sum);
    int t;
    @(negedge clk);
    a_bus = a;
    b_bus = b;
    exp_gnt_q.push_back(id);
    exp_id_q.push_back(id);
    exp_sum_q.push_back(exp_sum);
    req = mask;
    wait_gnt(t);
    req = '0;
    @(negedge clk);
  endtask

  initial begin
    int t0, t1, n;
    rst_n = 1'b0;
    req   = '0;
    a_bus = '0;
    b_bus = '0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_done_id", done_id, 0);
    chk("rst_ovf", ovf_cnt, 0);
    rst_n = 1'b1;

    // Reset mid-EXEC: operation abandoned, no done.
    @(negedge clk);
    a_bus = {2'd0, 2'd3};
    b_bus = {2'd0, 2'd1};
    exp_gnt_q.push_back(0);
    req = 2'b01;
    wait_gnt(t0);
    #2 rst_n = 1'b0;
    req = '0;
    #1;
    chk("midrst_gnt", gnt, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_sum", sum, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Pointer back to reset value: contention resolves to requester 0.
    op(2'b11, 0, {2'd3, 2'd1}, {2'd3, 2'd2}, 3);
    op(2'b01, 0, {2'd0, 2'd1}, {2'd0, 2'd2}, 3);
    op(2'b10, 1, {2'd3, 2'd0}, {2'd3, 2'd1}, 6);

    // Contention: four operations with both requests held.
    a_bus = {2'd2, 2'd1};
    b_bus = {2'd3, 2'd1};
    for (int i = 0; i < 4; i++) begin
      exp_gnt_q.push_back(i % 2);
      exp_id_q.push_back(i % 2);
      exp_sum_q.push_back((i % 2 == 0) ? 2 : 5);
    end
    spacing_en = 1'b1;
    last_done = -1;
    @(negedge clk);
    req = 2'b11;
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge clk);
      if (gnt != '0) n++;
    end
    chk("contention_grants", n, 4);
    req = '0;
    repeat (2) @(negedge clk);
    spacing_en = 1'b0;

    // Late request: req[1] raised during EXEC of requester 0.
    a_bus = {2'd1, 2'd2};
    b_bus = {2'd1, 2'd2};
    exp_gnt_q.push_back(0); exp_id_q.push_back(0); exp_sum_q.push_back(4);
    exp_gnt_q.push_back(1); exp_id_q.push_back(1); exp_sum_q.push_back(2);
    @(negedge clk);
    req = 2'b01;
    wait_gnt(t0);
    req = 2'b10;
    wait_gnt(t1);
    chk("late_gap", t1 - t0, 3);
    req = '0;
    @(negedge clk);

    // Withdrawn request: req[0] pulsed for one cycle while busy.
    a_bus = {2'd1, 2'd0};
    b_bus = {2'd2, 2'd2};
    exp_gnt_q.push_back(1); exp_id_q.push_back(1); exp_sum_q.push_back(3);
    @(negedge clk);
    req = 2'b10;
    wait_gnt(t0);
    req = 2'b01;
    @(negedge clk);
    req = '0;
    repeat (4) @(negedge clk);

    // Saturation: 300 carry-producing operations.
    for (int i = 0; i < 300; i++) op(2'b10, 1, {2'd3, 2'd0}, {2'd3, 2'd0}, 6);
    repeat (5) @(negedge clk);
`ifdef ADDER_ARB_OVF_COUNT_EN
    chk("ovf_saturated", ovf_cnt, 255);
`else
    chk("ovf_tied_zero", ovf_cnt, 0);
`endif
    chk("gnt_queue_drained", exp_gnt_q.size(), 0);
    chk("done_queue_drained", exp_sum_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end
endmodule
